// File: rtl/memory_game_pkg.sv
// Shared types and board constants for the memory card game.
// Imported by the turn controller, the pair blocks and the board top.
package memory_game_pkg;

  localparam int DEF_NUM_CARDS = 16;
  localparam int DEF_POS_W     = 5;

  // All-ones position: no card is being strobed.
  localparam logic [DEF_POS_W-1:0] NO_SEL =
    DEF_POS_W'(2**DEF_POS_W - 1);

  typedef enum logic [2:0] {
    PICK1,
    PICK2,
    SETTLE,
    HOLD,
    CHECKWIN,
    WON
  } turn_state_t;

  function automatic int max_int(input int a,
                                 input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/memory_turn_ctrl_timer.sv
// Loadable down-counter; expire pulses for one cycle when an armed
// count reaches zero.
module turn_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic         armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (armed) begin
      if (cnt == '0) begin
        armed <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign expire = armed && (cnt == '0);

endmodule

// File: rtl/memory_turn_ctrl.sv
// Turn controller: sequences two flips per turn, judges the pair,
// holds mismatches face-up, and tracks attempts, pairs and the win.
module memory_turn_ctrl
  import memory_game_pkg::*;
#(
  parameter int NUM_CARDS     = DEF_NUM_CARDS,
  parameter int POS_W         = DEF_POS_W,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pick_valid,
  input  logic [POS_W-1:0]     pick_pos,
  input  logic                 restart,
  input  logic [NUM_CARDS-1:0] out_of_game,
  output logic [POS_W-1:0]     select_pos,
  output logic                 unselect_all,
  output logic [NUM_CARDS-1:0] flipped_mask,
  output logic [7:0]           attempts,
  output logic [POS_W-1:0]     matched_pairs,
  output logic                 game_won,
  output logic                 busy
);

  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TW       = max_int(HOLD_W, SETTLE_W);

  localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES);

  localparam logic [POS_W-1:0] IDLE_POS = '1;
  localparam logic [POS_W-1:0] ALL_PAIRS =
    POS_W'(NUM_CARDS / 2);

  turn_state_t state, state_d;

  logic [POS_W-1:0]     first_pos, first_d;
  logic [POS_W-1:0]     second_pos, second_d;
  logic [POS_W-1:0]     sel_d;
  logic                 unsel_d;
  logic [NUM_CARDS-1:0] flip_d;
  logic [7:0]           att_d;
  logic [POS_W-1:0]     pairs_d;
  logic                 won_d;
  logic                 busy_d;

  logic [NUM_CARDS-1:0] pick_oh;
  logic [NUM_CARDS-1:0] first_oh;
  logic [NUM_CARDS-1:0] second_oh;
  logic                 pick_ok;
  logic                 pair_hit;

  logic                 tmr_clear;
  logic                 tmr_load;
  logic [TW-1:0]        tmr_val;
  logic                 expire;

  turn_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  // One-hot decodes avoid indexing the masks with out-of-range positions.
  always_comb begin
    pick_oh   = '0;
    first_oh  = '0;
    second_oh = '0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      pick_oh[i]   = (pick_pos == POS_W'(i));
      first_oh[i]  = (first_pos == POS_W'(i));
      second_oh[i] = (second_pos == POS_W'(i));
    end
  end

  assign pick_ok = pick_valid && (|pick_oh) &&
    !(|(pick_oh & (out_of_game | flipped_mask)));

  assign pair_hit = (|(first_oh & out_of_game)) &&
    (|(second_oh & out_of_game));

  always_comb begin
    state_d   = state;
    first_d   = first_pos;
    second_d  = second_pos;
    sel_d     = IDLE_POS;
    unsel_d   = 1'b0;
    flip_d    = flipped_mask;
    att_d     = attempts;
    pairs_d   = matched_pairs;
    won_d     = game_won;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = SETTLE_LD;

    if (restart) begin
      unsel_d   = 1'b1;
      flip_d    = '0;
      att_d     = '0;
      pairs_d   = '0;
      won_d     = 1'b0;
      tmr_clear = 1'b1;
      state_d   = PICK1;
    end else begin
      unique case (state)
        PICK1: begin
          if (pick_ok) begin
            first_d = pick_pos;
            sel_d   = pick_pos;
            flip_d  = flipped_mask | pick_oh;
            state_d = PICK2;
          end
        end
        PICK2: begin
          if (pick_ok) begin
            second_d = pick_pos;
            sel_d    = pick_pos;
            flip_d   = flipped_mask | pick_oh;
            if (attempts != 8'hFF) begin
              att_d = attempts + 8'd1;
            end
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
            state_d  = SETTLE;
          end
        end
        SETTLE: begin
          if (expire) begin
            if (pair_hit) begin
              pairs_d = matched_pairs + POS_W'(1);
              flip_d  = flipped_mask & ~(first_oh | second_oh);
              state_d = CHECKWIN;
            end else begin
              tmr_load = 1'b1;
              tmr_val  = HOLD_LD;
              state_d  = HOLD;
            end
          end
        end
        HOLD: begin
          if (expire) begin
            unsel_d = 1'b1;
            flip_d  = '0;
            state_d = PICK1;
          end
        end
        CHECKWIN: begin
          if (matched_pairs == ALL_PAIRS) begin
            won_d   = 1'b1;
            state_d = WON;
          end else begin
            state_d = PICK1;
          end
        end
        WON: begin
          state_d = WON;
        end
        default: begin
          state_d = PICK1;
        end
      endcase
    end

    busy_d = state_d inside {SETTLE, HOLD, CHECKWIN, WON};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PICK1;
      first_pos     <= '0;
      second_pos    <= '0;
      select_pos    <= IDLE_POS;
      unselect_all  <= 1'b0;
      flipped_mask  <= '0;
      attempts      <= '0;
      matched_pairs <= '0;
      game_won      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      first_pos     <= first_d;
      second_pos    <= second_d;
      select_pos    <= sel_d;
      unselect_all  <= unsel_d;
      flipped_mask  <= flip_d;
      attempts      <= att_d;
      matched_pairs <= pairs_d;
      game_won      <= won_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Directed bench for memory_turn_ctrl with a pair-block model and a
// strobe scoreboard.
module tb_memory_turn_ctrl;

  localparam int NC     = 16;
  localparam int PW     = 5;
  localparam int HOLD   = 8;
  localparam int SETTLE = 2;
  localparam logic [PW-1:0] NOSEL = 5'd31;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pick_valid = 1'b0;
  logic [PW-1:0] pick_pos = '0;
  logic          restart = 1'b0;
  logic [NC-1:0] model_oog;
  logic [NC-1:0] out_of_game;
  logic          hide_oog = 1'b0;

  logic [PW-1:0] select_pos;
  logic          unselect_all;
  logic [NC-1:0] flipped_mask;
  logic [7:0]    attempts;
  logic [PW-1:0] matched_pairs;
  logic          game_won;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] sb[$];
  logic [PW-1:0] exp_pos;

  logic          have_first;
  logic [PW-1:0] first_seen;

  always #5 clk = ~clk;

  assign out_of_game = hide_oog ? '0 : model_oog;

  memory_turn_ctrl #(
    .NUM_CARDS     (NC),
    .POS_W         (PW),
    .HOLD_CYCLES   (HOLD),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pick_valid    (pick_valid),
    .pick_pos      (pick_pos),
    .restart       (restart),
    .out_of_game   (out_of_game),
    .select_pos    (select_pos),
    .unselect_all  (unselect_all),
    .flipped_mask  (flipped_mask),
    .attempts      (attempts),
    .matched_pairs (matched_pairs),
    .game_won      (game_won),
    .busy          (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] partner(input logic [PW-1:0] p);
    return p ^ 5'd4;
  endfunction

  // Pair-block model: pairs are (p, p^4); a matched pair goes
  // out of game one cycle after its second strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_oog  <= '0;
      have_first <= 1'b0;
      first_seen <= '0;
    end else if (restart) begin
      model_oog  <= '0;
      have_first <= 1'b0;
    end else if (unselect_all) begin
      have_first <= 1'b0;
    end else if (select_pos != NOSEL) begin
      if (!have_first) begin
        have_first <= 1'b1;
        first_seen <= select_pos;
      end else begin
        have_first <= 1'b0;
        if (partner(first_seen) == select_pos) begin
          model_oog[first_seen[3:0]] <= 1'b1;
          model_oog[select_pos[3:0]] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && select_pos !== NOSEL) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'(select_pos), 32'(NOSEL));
      end else begin
        exp_pos = sb.pop_front();
        check("strobe", 32'(select_pos), 32'(exp_pos));
      end
    end
  end

  task automatic do_pick(input logic [PW-1:0] p, input bit acc);
    pick_valid = 1'b1;
    pick_pos   = p;
    if (acc) sb.push_back(p);
    @(negedge clk);
    pick_valid = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  logic [PW-1:0] firsts [8];

  initial begin
    int  k;
    int  seen;
    bit  done;

    firsts = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11};

    repeat (2) @(negedge clk);
    check("rst_sel", 32'(select_pos), 32'(NOSEL));
    check("rst_unsel", 32'(unselect_all), 0);
    check("rst_flip", 32'(flipped_mask), 0);
    check("rst_att", 32'(attempts), 0);
    check("rst_pairs", 32'(matched_pairs), 0);
    check("rst_won", 32'(game_won), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Match 3/7
    do_pick(5'd3, 1'b1);
    check("m_flip1", 32'(flipped_mask), 32'h0008);
    do_pick(5'd7, 1'b1);
    check("m_flip2", 32'(flipped_mask), 32'h0088);
    check("m_busy", 32'(busy), 1);
    seen = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (unselect_all) seen++;
      if (!busy) done = 1'b1;
    end
    check("m_done", 32'(done), 1);
    check("m_att", 32'(attempts), 1);
    check("m_pairs", 32'(matched_pairs), 1);
    check("m_flip", 32'(flipped_mask), 0);
    check("m_nounsel", 32'(seen), 0);

    // Illegal picks
    do_pick(5'd0, 1'b1);
    do_pick(5'd0, 1'b0);
    do_pick(5'd16, 1'b0);
    do_pick(5'd7, 1'b0);
    check("il_flip", 32'(flipped_mask), 32'h0001);
    check("il_att", 32'(attempts), 1);
    check("il_busy", 32'(busy), 0);
    do_pick(5'd1, 1'b1);
    repeat (4) @(negedge clk);
    check("il_hold_busy", 32'(busy), 1);
    do_pick(5'd2, 1'b0);
    check("il_hold_flip", 32'(flipped_mask), 32'h0003);
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (unselect_all) done = 1'b1;
      else @(negedge clk);
    end
    check("il_unsel", 32'(done), 1);
    check("il_flip0", 32'(flipped_mask), 0);
    check("il_att2", 32'(attempts), 2);
    check("il_pairs", 32'(matched_pairs), 1);
    @(negedge clk);
    check("il_idle", 32'(busy), 0);

    // Restart clears counters
    do_restart();
    check("rs_unsel", 32'(unselect_all), 1);
    check("rs_att", 32'(attempts), 0);
    check("rs_pairs", 32'(matched_pairs), 0);
    check("rs_sel", 32'(select_pos), 32'(NOSEL));

    // Mismatch 2/5 with hold timing
    do_pick(5'd2, 1'b1);
    do_pick(5'd5, 1'b1);
    k = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      k++;
      if (unselect_all) done = 1'b1;
      else check("mm_hold_flip", 32'(flipped_mask), 32'h0024);
    end
    check("mm_unsel", 32'(done), 1);
    check("mm_delay", k, SETTLE + HOLD + 2);
    check("mm_flip0", 32'(flipped_mask), 0);
    check("mm_att", 32'(attempts), 1);
    @(negedge clk);
    check("mm_pulse1", 32'(unselect_all), 0);
    check("mm_idle", 32'(busy), 0);

    // Restart on cycle 4 of HOLD
    do_pick(5'd0, 1'b1);
    do_pick(5'd1, 1'b1);
    repeat (6) @(negedge clk);
    check("rh_in_hold", 32'(busy), 1);
    do_restart();
    check("rh_unsel", 32'(unselect_all), 1);
    check("rh_att", 32'(attempts), 0);
    check("rh_flip", 32'(flipped_mask), 0);
    check("rh_busy", 32'(busy), 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (unselect_all) seen++;
    end
    check("rh_no_second", seen, 0);

    // Win: all eight pairs
    for (int p = 0; p < 8; p++) begin
      do_pick(firsts[p], 1'b1);
      do_pick(partner(firsts[p]), 1'b1);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        @(negedge clk);
        if (!busy || game_won) done = 1'b1;
      end
      check("w_turn", 32'(done), 1);
      check("w_pairs_step", 32'(matched_pairs), p + 1);
    end
    check("w_won", 32'(game_won), 1);
    check("w_busy", 32'(busy), 1);
    check("w_att", 32'(attempts), 8);
    hide_oog = 1'b1;
    @(negedge clk);
    do_pick(5'd0, 1'b0);
    do_pick(5'd5, 1'b0);
    check("w_ignore_flip", 32'(flipped_mask), 0);
    check("w_hold_won", 32'(game_won), 1);
    hide_oog = 1'b0;
    do_restart();
    check("w_rs_won", 32'(game_won), 0);
    check("w_rs_pairs", 32'(matched_pairs), 0);

    // Async reset mid-SETTLE
    do_pick(5'd0, 1'b1);
    do_pick(5'd4, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_sel", 32'(select_pos), 32'(NOSEL));
    check("ar_flip", 32'(flipped_mask), 0);
    check("ar_att", 32'(attempts), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_unsel", 32'(unselect_all), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_pick(5'd6, 1'b1);
    check("ar_pick_flip", 32'(flipped_mask), 32'h0040);
    check("ar_pick_busy", 32'(busy), 0);

    @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_turn_ctrl.md
Name: memory_turn_ctrl

Overview:
- Turn controller for the memory card game. It drives the selection bus that the pair blocks consume (select position strobe, unselect-all pulse) and reads back their per-position out-of-game flags.
- It accepts player picks, sequences two flips per turn and decides match or mismatch. On a mismatch it holds both cards face-up for a display time, then unflips them. It also counts attempts and matched pairs and flags the win.
- It sits between the input debouncer/cursor logic and the array of pair blocks.

Parameters:
- NUM_CARDS, 16, number of card positions; must be even and >= 4.
- POS_W, 5, width of position fields; must satisfy 2**POS_W > NUM_CARDS so that NO_SEL fits.
- HOLD_CYCLES, 25_000_000, mismatch display time in clocks; must be >= 1; benches use 8.
- SETTLE_CYCLES, 2, wait after the second flip before sampling out_of_game; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pick_valid  in  1  one-cycle strobe: player requests a flip.
- pick_pos  in  POS_W  position requested; valid when pick_valid=1.
- restart  in  1  synchronous new-game request.
- out_of_game  in  NUM_CARDS  bit i=1 means position i is already matched (from the pair blocks).
- select_pos  out  POS_W  position strobed to the pair blocks; equals NO_SEL when idle.
- unselect_all  out  1  one-cycle pulse that unflips every unmatched card.
- flipped_mask  out  NUM_CARDS  positions currently face-up and unmatched, for display.
- attempts  out  8  completed turns, saturating at 255.
- matched_pairs  out  POS_W  pairs matched this game.
- game_won  out  1  high once all pairs are matched, held until restart or reset.
- busy  out  1  high whenever a pick would be ignored for state reasons.

Behaviour:
- Reset (async, rst_n=0):
  - state=PICK1; select_pos=NO_SEL; unselect_all=0; flipped_mask=0; attempts=0; matched_pairs=0; game_won=0; busy=0.
  - All outputs are registered.
- Pick acceptance in PICK1/PICK2 requires pick_valid=1 and all of:
  - pick_pos < NUM_CARDS;
  - out_of_game[pick_pos]=0;
  - flipped_mask[pick_pos]=0.
  - Otherwise the pick is dropped silently and no state changes.
- On an accepted pick: select_pos=pick_pos for exactly one cycle (the next cycle), then it returns to NO_SEL. flipped_mask[pick_pos] is set in that same cycle.
- States:
  - PICK1: on an accepted pick, latch first_pos -> PICK2.
  - PICK2: on an accepted pick, latch second_pos; attempts+=1 (saturating); load the settle counter with SETTLE_CYCLES -> SETTLE.
  - SETTLE: count down; at 0, sample out_of_game[first_pos] & out_of_game[second_pos].
    - If both set (match): matched_pairs+=1; clear both flipped_mask bits -> CHECKWIN.
    - Otherwise (mismatch): load the hold counter with HOLD_CYCLES -> HOLD.
  - HOLD: count down; at 0, unselect_all=1 for one cycle and flipped_mask=0 -> PICK1.
  - CHECKWIN: one cycle. If matched_pairs==NUM_CARDS/2, game_won=1 -> WON; otherwise -> PICK1.
  - WON: all picks ignored; exits only on restart.
- busy=1 in SETTLE, HOLD, CHECKWIN and WON.
- restart in any state takes priority over every other event in that cycle:
  - next cycle unselect_all=1 (one-cycle pulse), select_pos=NO_SEL;
  - flipped_mask, attempts, matched_pairs and game_won are cleared;
  - state=PICK1.
  - A pick in the same cycle as restart is dropped.
- Async reset mid-HOLD or mid-SETTLE aborts immediately; no unselect_all pulse is emitted.
- Picks during busy states are not queued.
- A pick_valid that is held high is treated as one pick per cycle. The per-cycle acceptance rules prevent double-flipping the same position.
- The attempts counter saturates at 255 and never wraps.
- The hold and settle counters are sized as clog2(HOLD_CYCLES+1) and clog2(SETTLE_CYCLES+1).

Decomposition:
- Shared package memory_game_pkg holds:
  - the state enum turn_state_t (PICK1, PICK2, SETTLE, HOLD, CHECKWIN, WON);
  - the localparam NO_SEL = 2**POS_W-1;
  - the default NUM_CARDS and POS_W constants, shared with the pair blocks and the board top.
- One natural sub-module: turn_timer, a loadable down-counter with a done pulse. It is reused for both SETTLE and HOLD by loading the appropriate count.

Test Plan:
- Match: pick 3 then 7 with the bench model pairing (3,7); the model sets out_of_game[3]/[7] one cycle after the second strobe. Required: select_pos=3 then 7 on single cycles, attempts=1, matched_pairs=1, flipped_mask=0, back in PICK1, no unselect_all.
- Mismatch: pick 2 then 5 (not a pair), HOLD_CYCLES=8. Required: flipped_mask=0x0024 throughout HOLD; a single unselect_all pulse exactly SETTLE_CYCLES+8 (+ FSM overhead) cycles after the second strobe; then flipped_mask=0 and attempts=1.
- Illegal picks: pick 3 twice in a row, pick 16, pick an out_of_game position, and pick during HOLD. Required: none produce a select_pos strobe, and the state and counters are unchanged.
- Win: play all 8 pairs correctly with NUM_CARDS=16. Required: game_won=1 after the eighth match, matched_pairs=8, busy=1, and further picks ignored.
- Restart during HOLD: assert restart on cycle 4 of HOLD. Required: unselect_all pulse on the next cycle, counters zeroed, state PICK1, and no second unselect_all when HOLD would have expired.
- Async reset mid-SETTLE: drop rst_n asynchronously. Required: all outputs take their reset values immediately; after release, the first pick is accepted normally.
